// File: rtl/serial_shift_tx.sv
// serial_shift_tx: parallel-in, serial-out transmitter. Sends len+1 bits MSB-first or LSB-first.
// Latency: load at edge k, first bit in cycle k+1, last bit k+1+len, done k+2+len (+1 with parity).
// Backpressure: load_ready is high only in IDLE; load_valid at any other time is ignored.
// Optional: define SERIAL_SHIFT_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_shift_tx #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LEN_W-1:0] len,
   input  logic             dir,
   output logic             sdata,
   output logic             sframe,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
`ifdef SERIAL_SHIFT_TX_PARITY_EN
      PARITY,
`endif
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] shift_q;
   logic [LEN_W-1:0] cnt_q;
   logic             dir_q;
   logic             accept;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
   logic             par_q;
`endif

   // State register; reset abandons any transfer without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and outputs; outputs depend only on state so reset clears them at once.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      load_ready = 1'b0;
      busy       = 1'b0;
      sframe     = 1'b0;
      sdata      = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            busy   = 1'b1;
            sframe = 1'b1;
            sdata  = dir_q ? shift_q[0] : shift_q[WIDTH-1];
            if (cnt_q == '0) begin
`ifdef SERIAL_SHIFT_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef SERIAL_SHIFT_TX_PARITY_EN
         PARITY: begin
            busy    = 1'b1;
            sframe  = 1'b1;
            sdata   = par_q;
            state_d = DONE;
         end
`endif
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: capture the word on accept, then shift zero-filled and count down once per bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else if (accept) begin
         shift_q <= load_data;
         cnt_q   <= len;
         dir_q   <= dir;
      end else if (state_q == SHIFT) begin
         shift_q <= dir_q ? {1'b0, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], 1'b0};
         cnt_q   <= cnt_q - 1'b1;
      end
   end

`ifdef SERIAL_SHIFT_TX_PARITY_EN
   // Running XOR over only the bits actually placed on sdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else if (accept) begin
         par_q <= 1'b0;
      end else if (state_q == SHIFT) begin
         par_q <= par_q ^ sdata;
      end
   end
`endif

endmodule

// File: tb/tb_serial_shift_tx.sv
// tb_serial_shift_tx: randomized and directed bench for serial_shift_tx.
// Expected serial streams come from a queue model of the transmit order.
// Define SERIAL_SHIFT_TX_PARITY_EN for both DUT and bench to cover the parity build.
module tb_serial_shift_tx;
   localparam int WIDTH = 8;
   localparam int LEN_W = 3;

   logic             clk;
   logic             rst_n;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic [LEN_W-1:0] len;
   logic             dir;
   logic             sdata;
   logic             sframe;
   logic             busy;
   logic             done;

   int vectors;
   int miscompares;

   serial_shift_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .len        (len),
      .dir        (dir),
      .sdata      (sdata),
      .sframe     (sframe),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Observed outputs packed as {load_ready, busy, sframe, sdata, done}.
   function automatic logic [4:0] obs();
      return {load_ready, busy, sframe, sdata, done};
   endfunction

   // Drives one load at the current (IDLE, post-negedge) point and checks the whole frame.
   // If inj_at >= 0, a second load request is raised during that shift cycle and left high.
   task automatic test_transfer(input logic [WIDTH-1:0] d, input int n, input logic dr,
                                input string name, input int inj_at,
                                input logic [WIDTH-1:0] inj_d);
      bit   order[$];
      bit   par;
      logic [4:0] exp;
      for (int i = 0; i < WIDTH; i++)
         order.push_back(dr ? d[i] : d[WIDTH-1-i]);
      par = 1'b0;
      load_valid = 1'b1;
      load_data  = d;
      len        = LEN_W'(n);
      dir        = dr;
      vectors++;
      if (obs() !== 5'b10000) begin
         miscompares++;
         $display("FAIL %s idle-before-load: got %b want 10000", name, obs());
      end
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      load_data  = WIDTH'($urandom);
      len        = LEN_W'($urandom);
      dir        = 1'($urandom);
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         exp = {1'b0, 1'b1, 1'b1, order[i], 1'b0};
         par = par ^ order[i];
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL %s bit%0d: got %b want %b", name, i, obs(), exp);
         end
         if (i == inj_at) begin
            load_valid = 1'b1;
            load_data  = inj_d;
            len        = LEN_W'(WIDTH - 1);
            dir        = 1'b0;
         end
      end
`ifdef SERIAL_SHIFT_TX_PARITY_EN
      @(negedge clk);
      exp = {1'b0, 1'b1, 1'b1, par, 1'b0};
      vectors++;
      if (obs() !== exp) begin
         miscompares++;
         $display("FAIL %s parity: got %b want %b", name, obs(), exp);
      end
`endif
      @(negedge clk);
      vectors++;
      if (obs() !== 5'b01001) begin
         miscompares++;
         $display("FAIL %s done: got %b want 01001", name, obs());
      end
      @(negedge clk);
      vectors++;
      if (obs() !== 5'b10000) begin
         miscompares++;
         $display("FAIL %s ready-return: got %b want 10000", name, obs());
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      len        = '0;
      dir        = 1'b0;
      #1;
      vectors++;
      if (obs() !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset-state: got %b want 10000", obs());
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs() !== 5'b10000) begin
         miscompares++;
         $display("FAIL post-reset-idle: got %b want 10000", obs());
      end
   endtask

   task automatic test_directed();
      test_transfer(8'b10101010, 7, 1'b0, "left_full", -1, '0);
      test_transfer(8'b10101010, 7, 1'b1, "right_full", -1, '0);
      test_transfer(8'b11000001, 2, 1'b0, "partial_left", -1, '0);
      test_transfer(8'b11000001, 2, 1'b1, "partial_right", -1, '0);
      test_transfer(8'b10000000, 0, 1'b0, "single_bit", -1, '0);
      test_transfer(8'b00000001, 0, 1'b1, "single_bit_r", -1, '0);
   endtask

   // Second request raised in the 3rd shift cycle must wait until IDLE, then be taken.
   task automatic test_ignored_load();
      test_transfer(8'hF0, 7, 1'b0, "ignored_first", 2, 8'h0F);
      test_transfer(8'h0F, 7, 1'b0, "ignored_second", -1, '0);
   endtask

   task automatic test_reset_mid();
      load_valid = 1'b1;
      load_data  = 8'h3C;
      len        = 3'd7;
      dir        = 1'b0;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (obs() !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset-mid immediate: got %b want 10000", obs());
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if (obs() !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset-mid held%0d: got %b want 10000", c, obs());
         end
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if (obs() !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset-mid released%0d: got %b want 10000", c, obs());
         end
      end
      test_transfer(8'h81, 7, 1'b0, "after_reset", -1, '0);
   endtask

   task automatic test_random();
      int gap;
      for (int t = 0; t < 40; t++) begin
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            vectors++;
            if (obs() !== 5'b10000) begin
               miscompares++;
               $display("FAIL random idle gap t%0d: got %b want 10000", t, obs());
            end
         end
         test_transfer(WIDTH'($urandom), $urandom_range(0, WIDTH - 1), 1'($urandom),
                       "random", -1, '0);
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 6; t++)
         test_transfer(WIDTH'($urandom), $urandom_range(0, WIDTH - 1), 1'($urandom),
                       "back_to_back", -1, '0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_directed();
      test_ignored_load();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/serial_shift_tx.md
Name: serial_shift_tx

Overview:
- Parallel-in, serial-out transmitter; the sequential counterpart to the team's combinational left/right shifter.
- Accepts a WIDTH-bit word, a bit count and a direction through a valid/ready load handshake.
- Shifts the word out one bit per clock, MSB-first (left) or LSB-first (right).
- Feeds the serial links between datapath blocks; its output is framed for a matching serial receiver.

Parameters:
- WIDTH, 8, data word width in bits (minimum 2).
- LEN_W, 3, width of the len field; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load request; load_data, len and dir are qualified by it.
- load_ready  output  1  high only in IDLE; a load is accepted on a clock edge where load_valid && load_ready.
- load_data  input  WIDTH  word to transmit.
- len  input  LEN_W  number of bits to send minus 1; 0 sends 1 bit, 7 sends 8 bits.
- dir  input  1  0 = left shift, MSB first; 1 = right shift, LSB first.
- sdata  output  1  serial data bit; 0 whenever sframe is 0.
- sframe  output  1  high for exactly the cycles carrying valid bits.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  single-cycle pulse after the last bit.

Behaviour:
- Reset, asynchronous, from any state: state=IDLE, load_ready=1, sdata=0, sframe=0, busy=0, done=0, shift register and counter cleared. A transfer in progress is abandoned and does not resume after reset; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1.
  - On an accepted load: latch load_data into the shift register, latch dir, set counter=len, go to SHIFT.
  - Without load_valid, stay in IDLE.
- SHIFT:
  - sframe=1, busy=1.
  - sdata = reg[WIDTH-1] when dir=0, reg[0] when dir=1.
  - On each edge: shift one place left (dir=0) or right (dir=1), zero-filled; decrement counter.
  - When counter==0 at the edge, go to DONE.
- DONE: done=1, busy=1, sframe=0, sdata=0, load_ready=0. Next edge goes to IDLE.
- Latency: load accepted at edge k; first bit valid in cycle k+1; last bit in cycle k+1+len; done in cycle k+2+len; load_ready returns in cycle k+3+len.
- load_valid while not in IDLE is ignored; the in-flight transfer is unaffected.
- Changes to dir, len or load_data after acceptance have no effect.
- len > WIDTH-1 is impossible when LEN_W = clog2(WIDTH); the block does not check it.
- Bits beyond len+1 are never output.
- Back-to-back loads: minimum spacing is len+3 cycles between accepts.

Optional Feature:
- Macro: SERIAL_SHIFT_TX_PARITY_EN.
- Defined:
  - After the last data bit, one extra cycle with sframe=1 and sdata = even parity (XOR) of the bits actually transmitted, i.e. only the len+1 sent bits.
  - Implemented as a PARITY state between SHIFT and DONE.
  - done, and every later event, moves one cycle later.
- Not defined: no PARITY state and no parity logic; timing exactly as in Behaviour.

Test Plan:
- Left, full word: load 8'b10101010, len=7, dir=0 -> sdata 1,0,1,0,1,0,1,0 over 8 cycles with sframe=1; done pulses in the 9th cycle; load_ready back the cycle after.
- Right, full word: load 8'b10101010, len=7, dir=1 -> sdata 0,1,0,1,0,1,0,1; sframe high exactly 8 cycles.
- Partial length: load 8'b11000001, len=2, dir=0 -> sdata 1,1,0 then done; the trailing 1 is never output. Same word with dir=1 -> sdata 1,0,0.
- Ignored load: load 8'hF0; assert load_valid with 8'h0F in the 3rd shift cycle -> output stream remains 8'hF0's bits; load_ready=0 throughout; the second word is only taken if load_valid is still high once IDLE is reached.
- Reset mid-transfer: drop rst_n low asynchronously in the 4th shift cycle -> sframe=0, sdata=0, busy=0 immediately; no done pulse; after release, load_ready=1 and a fresh load of 8'h81, len=7, dir=0 transmits correctly.
- Parity (macro defined): load 8'b10101010, len=7, dir=0 -> 8 data bits then parity bit 0; load 8'b10000000, len=0 -> bit 1 then parity 1; done one cycle later than in the non-parity build.
